// File: rtl/decode_queue.sv
// Decode stage + DEPTH-entry FIFO between fetch and execute of the 19-bit CPU.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal ops flag illegal_o and raise a sticky input trap.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int IMM_W = 19,
   parameter int PC_W  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [18:0]                  instr_i,
   input  logic [PC_W-1:0]              pc_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [2:0]                   rs1_o,
   output logic [2:0]                   rs2_o,
   output logic [2:0]                   rd_o,
   output logic [3:0]                   op_o,
   output logic [2:0]                   funct3_o,
   output logic [2:0]                   funct7_o,
   output logic                         r_type_o,
   output logic                         i_type_o,
   output logic                         s_type_o,
   output logic                         b_type_o,
   output logic                         u_type_o,
   output logic                         j_type_o,
   output logic [IMM_W-1:0]             imm_o,
   output logic [PC_W-1:0]              pc_o,
   output logic                         illegal_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [3:0] R_TYPE   = 4'h0;
   localparam logic [3:0] I_TYPE_0 = 4'h1;
   localparam logic [3:0] I_TYPE_1 = 4'h2;
   localparam logic [3:0] I_TYPE_2 = 4'h3;
   localparam logic [3:0] S_TYPE   = 4'h4;
   localparam logic [3:0] B_TYPE   = 4'h5;
   localparam logic [3:0] U_TYPE_0 = 4'h6;
   localparam logic [3:0] U_TYPE_1 = 4'h7;
   localparam logic [3:0] J_TYPE   = 4'h8;

   typedef struct packed {
      logic [2:0]       rs1;
      logic [2:0]       rs2;
      logic [2:0]       rd;
      logic [3:0]       op;
      logic [2:0]       f3;
      logic [2:0]       f7;
      logic [5:0]       flags;   // {r,i,s,b,u,j}
      logic [IMM_W-1:0] imm;
      logic [PC_W-1:0]  pc;
      logic             ill;
   } pkt_t;

   pkt_t              r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_trap;

   pkt_t              w_pkt, w_out;
   logic              w_push, w_pop, w_full, w_empty;
   logic signed [2:0]  w_imm_i;
   logic signed [8:0]  w_imm_s;
   logic signed [9:0]  w_imm_b;
   logic signed [12:0] w_imm_j;

   assign w_imm_i = instr_i[18:16];
   assign w_imm_s = {instr_i[18:13], instr_i[9:7]};
   assign w_imm_b = {instr_i[18:13], instr_i[6:4], 1'b0};
   assign w_imm_j = {instr_i[18:7], 1'b0};

   always_comb begin
      w_pkt     = '0;
      w_pkt.rs1 = instr_i[12:10];
      w_pkt.rs2 = instr_i[15:13];
      w_pkt.rd  = instr_i[6:4];
      w_pkt.op  = instr_i[3:0];
      w_pkt.f3  = instr_i[9:7];
      w_pkt.f7  = instr_i[18:16];
      w_pkt.pc  = pc_i;
      case (instr_i[3:0])
         R_TYPE: w_pkt.flags = 6'b100000;
         I_TYPE_0, I_TYPE_1, I_TYPE_2: begin
            w_pkt.flags = 6'b010000;
            w_pkt.imm   = IMM_W'($signed(w_imm_i));
         end
         S_TYPE: begin
            w_pkt.flags = 6'b001000;
            w_pkt.imm   = IMM_W'($signed(w_imm_s));
         end
         B_TYPE: begin
            w_pkt.flags = 6'b000100;
            w_pkt.imm   = IMM_W'($signed(w_imm_b));
         end
         U_TYPE_0, U_TYPE_1: begin
            w_pkt.flags = 6'b000010;
            w_pkt.imm   = IMM_W'({instr_i[18:7], 7'b0});
         end
         J_TYPE: begin
            w_pkt.flags = 6'b000001;
            w_pkt.imm   = IMM_W'($signed(w_imm_j));
         end
         default: ;
      endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
      w_pkt.ill = ~|w_pkt.flags;
`endif
   end

   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign in_ready_o  = ~w_full & ~r_trap;
   assign out_valid_o = ~w_empty;
   assign w_push      = in_valid_i & in_ready_o;
   assign w_pop       = out_valid_o & out_ready_i;
   assign count_o     = r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   // Sticky: only flush or reset reopens the input after an illegal push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          r_trap <= 1'b0;
      else if (flush_i)                     r_trap <= 1'b0;
      else if (w_push && w_pkt.ill)         r_trap <= 1'b1;
   end
`else
   assign r_trap = 1'b0;
`endif

   // Packet storage carries no reset; occupancy gating hides stale entries.
   always_ff @(posedge clk_i) begin
      if (w_push && !flush_i) r_mem[r_wptr] <= w_pkt;
   end

   assign w_out    = out_valid_o ? r_mem[r_rptr] : '0;
   assign rs1_o    = w_out.rs1;
   assign rs2_o    = w_out.rs2;
   assign rd_o     = w_out.rd;
   assign op_o     = w_out.op;
   assign funct3_o = w_out.f3;
   assign funct7_o = w_out.f7;
   assign r_type_o = w_out.flags[5];
   assign i_type_o = w_out.flags[4];
   assign s_type_o = w_out.flags[3];
   assign b_type_o = w_out.flags[2];
   assign u_type_o = w_out.flags[1];
   assign j_type_o = w_out.flags[0];
   assign imm_o    = w_out.imm;
   assign pc_o     = w_out.pc;
   assign illegal_o = w_out.ill;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue; expectations are hand-computed constants.
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int IMM_W = 19;
   localparam int PC_W  = 16;

   localparam logic [3:0] OP_R  = 4'h0;
   localparam logic [3:0] OP_I0 = 4'h1;
   localparam logic [3:0] OP_S  = 4'h4;
   localparam logic [3:0] OP_B  = 4'h5;
   localparam logic [3:0] OP_U0 = 4'h6;
   localparam logic [3:0] OP_J  = 4'h8;

   logic              clk = 1'b0;
   logic              rst_ni = 1'b0;
   logic              flush_i = 1'b0;
   logic              in_valid_i = 1'b0;
   logic              in_ready_o;
   logic [18:0]       instr_i = '0;
   logic [PC_W-1:0]   pc_i = '0;
   logic              out_valid_o;
   logic              out_ready_i = 1'b0;
   logic [2:0]        rs1_o, rs2_o, rd_o, funct3_o, funct7_o;
   logic [3:0]        op_o;
   logic              r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o;
   logic [IMM_W-1:0]  imm_o;
   logic [PC_W-1:0]   pc_o;
   logic              illegal_o;
   logic [2:0]        count_o;

   int n_vec = 0;
   int n_err = 0;

   decode_queue #(.DEPTH(DEPTH), .IMM_W(IMM_W), .PC_W(PC_W)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .op_o(op_o),
      .funct3_o(funct3_o), .funct7_o(funct7_o),
      .r_type_o(r_type_o), .i_type_o(i_type_o), .s_type_o(s_type_o),
      .b_type_o(b_type_o), .u_type_o(u_type_o), .j_type_o(j_type_o),
      .imm_o(imm_o), .pc_o(pc_o), .illegal_o(illegal_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] mk(input logic [2:0] f7, input logic [2:0] rs2,
                                      input logic [2:0] rs1, input logic [2:0] f3,
                                      input logic [2:0] rd, input logic [3:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [5:0] flags();
      return {r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [18:0] ins, input logic [PC_W-1:0] pc);
      in_valid_i = 1'b1;
      instr_i    = ins;
      pc_i       = pc;
      tick();
      in_valid_i = 1'b0;
   endtask

   task automatic pop_one();
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
   endtask

   initial begin
      // Reset state, sampled while reset is held
      #2;
      chk("rst_count", count_o, 0);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_ready", in_ready_o, 1);
      chk("rst_imm",   imm_o, 0);
      tick();
      rst_ni = 1'b1;
      tick();

      // I-type, negative immediate, and no pass-through before the edge
      in_valid_i = 1'b1;
      instr_i    = mk(3'b101, 3'd0, 3'd5, 3'd0, 3'd2, OP_I0);
      pc_i       = 16'h0040;
      #1;
      chk("i_nobypass", out_valid_o, 0);
      tick();
      in_valid_i = 1'b0;
      chk("i_valid", out_valid_o, 1);
      chk("i_flag",  flags(), 6'b010000);
      chk("i_imm",   imm_o, 19'h7FFFD);
      chk("i_rd",    rd_o, 2);
      chk("i_rs1",   rs1_o, 5);
      chk("i_pc",    pc_o, 16'h0040);
      tick();
      chk("i_hold_pc", pc_o, 16'h0040);
      pop_one();
      chk("i_empty", out_valid_o, 0);

      // Fill to full, reject a fifth, drain in order
      for (int k = 0; k < 4; k++)
         push_one(mk(3'd0, 3'd1, 3'd2, 3'd3, 3'(k), OP_R), 16'h0100 + 16'(k));
      chk("full_count", count_o, 4);
      chk("full_ready", in_ready_o, 0);
      push_one(mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd7, OP_R), 16'h01FF);
      chk("full_reject", count_o, 4);
      for (int k = 0; k < 4; k++) begin
         chk("drain_pc", pc_o, 16'h0100 + 16'(k));
         chk("drain_rd", rd_o, k);
         pop_one();
      end
      chk("drain_valid", out_valid_o, 0);
      chk("drain_pc0",   pc_o, 0);
      chk("drain_flag0", flags(), 0);

      // Streaming at occupancy 2 with pointer wrap
      push_one(mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, OP_R), 16'h0200);
      push_one(mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd1, OP_R), 16'h0201);
      out_ready_i = 1'b1;
      in_valid_i  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         instr_i = mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, OP_R);
         pc_i    = 16'h0202 + 16'(k);
         chk("stream_count", count_o, 2);
         chk("stream_pc", pc_o, 16'h0200 + 16'(k));
         tick();
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      chk("stream_end_count", count_o, 2);
      chk("stream_tail0", pc_o, 16'h020A);
      pop_one();
      chk("stream_tail1", pc_o, 16'h020B);
      pop_one();
      chk("stream_empty", out_valid_o, 0);

      // Flush beats simultaneous push and pop
      for (int k = 0; k < 3; k++)
         push_one(mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, OP_R), 16'h0300 + 16'(k));
      chk("pre_flush_count", count_o, 3);
      flush_i     = 1'b1;
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      pc_i        = 16'h03FF;
      tick();
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      chk("flush_count", count_o, 0);
      chk("flush_valid", out_valid_o, 0);
      tick();
      chk("flush_dropped", count_o, 0);

      // Immediate formats with instr[18]=1
      push_one({12'h800, 3'd0, OP_J}, 16'h0400);
      chk("j_flag", flags(), 6'b000001);
      chk("j_imm",  imm_o, 19'h7F000);
      pop_one();
      push_one({12'hFFF, 3'd0, OP_U0}, 16'h0401);
      chk("u_flag", flags(), 6'b000010);
      chk("u_imm",  imm_o, 19'h7FF80);
      pop_one();
      push_one(mk(3'b100, 3'b010, 3'd0, 3'b011, 3'd0, OP_S), 16'h0402);
      chk("s_flag", flags(), 6'b001000);
      chk("s_imm",  imm_o, 19'h7FF13);
      pop_one();
      push_one(mk(3'b110, 3'b001, 3'd0, 3'd0, 3'b101, OP_B), 16'h0403);
      chk("b_flag", flags(), 6'b000100);
      chk("b_imm",  imm_o, 19'h7FF1A);
      pop_one();
      push_one(mk(3'b111, 3'd1, 3'd1, 3'd1, 3'd1, OP_R), 16'h0404);
      chk("r_flag", flags(), 6'b100000);
      chk("r_imm",  imm_o, 0);
      chk("r_f7",   funct7_o, 3'b111);
      pop_one();

      // Undefined opcode followed by an R-type
      push_one(mk(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 4'hF), 16'h0500);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("ill_count", count_o, 1);
      chk("ill_flag",  illegal_o, 1);
      chk("ill_ready", in_ready_o, 0);
      push_one(mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, OP_R), 16'h0501);
      chk("ill_reject", count_o, 1);
      pop_one();
      chk("ill_drained", out_valid_o, 0);
      chk("ill_still_trap", in_ready_o, 0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("ill_flush_ready", in_ready_o, 1);
`else
      push_one(mk(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, OP_R), 16'h0501);
      chk("ill_count", count_o, 2);
      chk("ill_flags", flags(), 0);
      chk("ill_imm",   imm_o, 0);
      chk("ill_op",    op_o, 4'hF);
      chk("ill_out",   illegal_o, 0);
      pop_one();
      chk("ill_next_r", flags(), 6'b100000);
      chk("ill_next_pc", pc_o, 16'h0501);
      pop_one();
`endif

      // Asynchronous reset mid-cycle with two entries queued
      push_one({12'h800, 3'd0, OP_J}, 16'h0600);
      push_one({12'hFFF, 3'd0, OP_U0}, 16'h0601);
      chk("pre_arst_count", count_o, 2);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", out_valid_o, 0);
      chk("arst_count", count_o, 0);
      chk("arst_imm",   imm_o, 0);
      chk("arst_pc",    pc_o, 0);
      chk("arst_ready", in_ready_o, 1);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("post_arst_count", count_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
